// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, state enum and slice helper for regfile_mp
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_t;

    // Low bit of field `port` in a packed vector of `width`-bit fields.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - sequenced clear sweep, one register index per cycle
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clr_req,
    output logic                    o_clr_active,
    output logic [$clog2(NREG)-1:0] o_clr_idx,
    output logic                    o_ready
);

    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] IDX_LAST = AW'(NREG - 1);

    rf_state_t         r_state;
    rf_state_t         w_state_nxt;
    logic [AW-1:0]     r_idx;
    logic [AW-1:0]     w_idx_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // A clear request during a sweep restarts it from index 0.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_CLEAR: begin
                if (i_clr_req) begin
                    w_idx_nxt = '0;
                end else if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
            ST_RUN: begin
                if (i_clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign o_clr_active = (r_state == ST_CLEAR);
    assign o_clr_idx    = r_idx;
    assign o_ready      = (r_state == ST_RUN);

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with bypass and pending scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = NRD_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_clr_req,
    output logic                          o_ready,
    input  logic                          i_we,
    input  logic [$clog2(NREG)-1:0]       i_waddr,
    input  logic [XLEN-1:0]               i_wdata,
    input  logic                          i_iss_en,
    input  logic [$clog2(NREG)-1:0]       i_iss_rd,
    input  logic [NRD*$clog2(NREG)-1:0]   i_raddr,
    output logic [NRD*XLEN-1:0]           o_rdata,
    output logic [NRD-1:0]                o_rpend
);

    localparam int AW = $clog2(NREG);

    logic                w_clr_active;
    logic [AW-1:0]       w_clr_idx;
    logic                w_wr_ok;
    logic                w_iss_ok;
    logic [XLEN-1:0]     r_regs [NREG];
    logic [NREG-1:0]     r_pend;

    regfile_clear_fsm #(
        .NREG(NREG)
    ) u_clear_fsm (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clr_req    (i_clr_req),
        .o_clr_active (w_clr_active),
        .o_clr_idx    (w_clr_idx),
        .o_ready      (o_ready)
    );

    assign w_wr_ok  = !w_clr_active && i_we && (i_waddr != '0);
    assign w_iss_ok = !w_clr_active && i_iss_en && (i_iss_rd != '0);

    always_ff @(posedge i_clk) begin
        if (w_clr_active) begin
            r_regs[w_clr_idx] <= '0;
        end else if (w_wr_ok) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Issue is applied after writeback so a same-index collision leaves the bit set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend <= '0;
        end else if (w_clr_active) begin
            r_pend[w_clr_idx] <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_pend[i_waddr] <= 1'b0;
            end
            if (w_iss_ok) begin
                r_pend[i_iss_rd] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;
        logic            w_rp;

        assign w_ra = i_raddr[slice_lo(p, AW) +: AW];

        always_comb begin
            w_rd = '0;
            w_rp = 1'b0;
            if (w_clr_active || (w_ra == '0)) begin
                w_rd = '0;
                w_rp = 1'b0;
            end else if (i_we && (i_waddr == w_ra)) begin
                w_rd = i_wdata;
                w_rp = i_iss_en && (i_iss_rd == w_ra);
            end else begin
                w_rd = r_regs[w_ra];
                w_rp = r_pend[w_ra];
            end
        end

        assign o_rdata[slice_lo(p, XLEN) +: XLEN] = w_rd;
        assign o_rpend[p] = w_rp;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (default and 4-port 16x16 instances)
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr_req, we, iss_en, ready;
    logic [4:0]  waddr, iss_rd;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rpend;

    logic        b_clr_req, b_we, b_iss_en, b_ready;
    logic [3:0]  b_waddr, b_iss_rd;
    logic [15:0] b_wdata;
    logic [15:0] b_raddr;
    logic [63:0] b_rdata;
    logic [3:0]  b_rpend;

    int total = 0;
    int bad   = 0;

    regfile_mp dut_a (
        .i_clk(clk), .i_rst(rst), .i_clr_req(clr_req), .o_ready(ready),
        .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
        .i_iss_en(iss_en), .i_iss_rd(iss_rd),
        .i_raddr(raddr), .o_rdata(rdata), .o_rpend(rpend)
    );

    regfile_mp #(.XLEN(16), .NREG(16), .NRD(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_clr_req(b_clr_req), .o_ready(b_ready),
        .i_we(b_we), .i_waddr(b_waddr), .i_wdata(b_wdata),
        .i_iss_en(b_iss_en), .i_iss_rd(b_iss_rd),
        .i_raddr(b_raddr), .o_rdata(b_rdata), .o_rpend(b_rpend)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ir;
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;
        logic        p0, p1;
    } vec_t;

    typedef struct {
        logic [31:0] e0, e1;
        logic        p0, p1;
    } exp_t;

    vec_t tbl[14];
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ir,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic p0, input logic p1);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.ie = ie; v.ir = ir;
        v.ra0 = r0; v.ra1 = r1; v.e0 = e0; v.e1 = e1; v.p0 = p0; v.p1 = p1;
        return v;
    endfunction

    // Counts cycles from the current point until ready rises on each instance.
    task automatic count_sweep(output int ca, output int cb, output int nz);
        ca = -1; cb = -1; nz = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cb < 0 && b_ready) cb = c;
            if (ready) begin
                ca = c;
                break;
            end
            if (rdata !== 64'd0 || rpend !== 2'd0) nz++;
            tick();
        end
    endtask

    task automatic read_all_zero(input string nm);
        int nz = 0;
        for (int i = 1; i < 32; i++) begin
            raddr = {5'(i), 5'(i)};
            @(negedge clk);
            if (rdata !== 64'd0 || rpend !== 2'd0) nz++;
            tick();
        end
        chk(nm, 64'(nz), 64'd0);
    endtask

    initial begin
        int ca, cb, nz, cnt;
        exp_t ex;

        rst = 1'b1; clr_req = 1'b0; we = 1'b0; iss_en = 1'b0;
        waddr = '0; wdata = '0; iss_rd = '0; raddr = {5'd3, 5'd5};
        b_clr_req = 1'b0; b_we = 1'b0; b_iss_en = 1'b0;
        b_waddr = '0; b_wdata = '0; b_iss_rd = '0; b_raddr = '0;

        tick();
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rpend", 64'(rpend), 64'd0);
        chk("rst_b_ready", 64'(b_ready), 64'd0);
        tick();
        rst = 1'b0;
        count_sweep(ca, cb, nz);
        chk("sweep_len_a", 64'(ca), 64'd32);
        chk("sweep_len_b", 64'(cb), 64'd16);
        chk("sweep_reads_zero", 64'(nz), 64'd0);
        read_all_zero("post_sweep_zero");

        // Four-port instance: same index on two ports plus bypass on one port.
        b_we = 1'b1;
        b_waddr = 4'd1;  b_wdata = 16'h0101; tick();
        b_waddr = 4'd2;  b_wdata = 16'h0202; tick();
        b_waddr = 4'd15; b_wdata = 16'h0F0F; tick();
        b_we = 1'b0;
        b_raddr = {4'd15, 4'd2, 4'd1, 4'd1};
        @(negedge clk);
        chk("b_p0", 64'(b_rdata[15:0]),  64'h0101);
        chk("b_p1", 64'(b_rdata[31:16]), 64'h0101);
        chk("b_p2", 64'(b_rdata[47:32]), 64'h0202);
        chk("b_p3", 64'(b_rdata[63:48]), 64'h0F0F);
        chk("b_rpend", 64'(b_rpend), 64'd0);
        tick();
        b_we = 1'b1; b_waddr = 4'd2; b_wdata = 16'h2222;
        @(negedge clk);
        chk("b_bypass_all", b_rdata, 64'h0F0F_2222_0101_0101);
        tick();
        b_we = 1'b0;

        tbl[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0, 5,  0,  32'hDEADBEEF, 32'h0,        0, 0);
        tbl[1]  = mk(0, 0,  32'h0,        0, 0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        tbl[2]  = mk(1, 0,  32'h1234,     0, 0, 0,  5,  32'h0,        32'hDEADBEEF, 0, 0);
        tbl[3]  = mk(0, 0,  32'h0,        1, 7, 7,  0,  32'h0,        32'h0,        0, 0);
        tbl[4]  = mk(0, 0,  32'h0,        0, 0, 7,  7,  32'h0,        32'h0,        1, 1);
        tbl[5]  = mk(1, 7,  32'h55,       0, 0, 7,  5,  32'h55,       32'hDEADBEEF, 0, 0);
        tbl[6]  = mk(0, 0,  32'h0,        0, 0, 7,  7,  32'h55,       32'h55,       0, 0);
        tbl[7]  = mk(1, 7,  32'hAA,       1, 7, 7,  3,  32'hAA,       32'h0,        1, 0);
        tbl[8]  = mk(0, 0,  32'h0,        0, 0, 7,  7,  32'hAA,       32'hAA,       1, 1);
        tbl[9]  = mk(0, 0,  32'h0,        1, 0, 0,  7,  32'h0,        32'hAA,       0, 1);
        tbl[10] = mk(1, 7,  32'h77,       1, 3, 7,  0,  32'h77,       32'h0,        0, 0);
        tbl[11] = mk(0, 0,  32'h0,        0, 0, 3,  7,  32'h0,        32'h77,       1, 0);
        tbl[12] = mk(1, 31, 32'hFFFFFFFF, 0, 0, 31, 31, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        tbl[13] = mk(0, 0,  32'h0,        0, 0, 31, 30, 32'hFFFFFFFF, 32'h0,        0, 0);

        for (int i = 0; i < 14; i++) begin
            we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
            iss_en = tbl[i].ie; iss_rd = tbl[i].ir;
            raddr = {tbl[i].ra1, tbl[i].ra0};
            sbq.push_back('{tbl[i].e0, tbl[i].e1, tbl[i].p0, tbl[i].p1});
            @(negedge clk);
            ex = sbq.pop_front();
            chk($sformatf("tbl%0d_rd0", i), 64'(rdata[31:0]),  64'(ex.e0));
            chk($sformatf("tbl%0d_rd1", i), 64'(rdata[63:32]), 64'(ex.e1));
            chk($sformatf("tbl%0d_rp0", i), 64'(rpend[0]), 64'(ex.p0));
            chk($sformatf("tbl%0d_rp1", i), 64'(rpend[1]), 64'(ex.p1));
            tick();
        end
        we = 1'b0; iss_en = 1'b0;

        // Fill, mark one pending, then clear with a write attempted mid-sweep.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i) * 32'h01010101;
            tick();
        end
        we = 1'b0;
        iss_en = 1'b1; iss_rd = 5'd10; tick();
        iss_en = 1'b0;
        raddr = {5'd10, 5'd20};
        @(negedge clk);
        chk("fill_rd20", 64'(rdata[31:0]), 64'h14141414);
        chk("fill_pend10", 64'(rpend[1]), 64'd1);
        tick();
        clr_req = 1'b1; tick();
        clr_req = 1'b0;
        raddr = {5'd10, 5'd4};
        cnt = -1; nz = 0;
        for (int c = 0; c < 100; c++) begin
            we = (c == 2); waddr = 5'd4; wdata = 32'hBAD0BAD0;
            @(negedge clk);
            if (ready) begin
                cnt = c;
                break;
            end
            if (rdata !== 64'd0 || rpend !== 2'd0) nz++;
            tick();
        end
        we = 1'b0;
        chk("clr_len", 64'(cnt), 64'd32);
        chk("clr_reads_zero", 64'(nz), 64'd0);
        read_all_zero("post_clr_zero");

        // Reset in sweep cycle 10 restarts both instances.
        clr_req = 1'b1; tick();
        clr_req = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        @(negedge clk);
        chk("restart_pre_ready", 64'(ready), 64'd0);
        rst = 1'b1; tick();
        rst = 1'b0;
        count_sweep(ca, cb, nz);
        chk("restart_len_a", 64'(ca), 64'd32);
        chk("restart_len_b", 64'(cb), 64'd16);
        chk("restart_reads_zero", 64'(nz), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
